// File: rtl/gb_mbc_pkg.sv
// Shared region map, keys and types for the Game Boy bank-controller family.
// Every region is power-of-two sized and aligned, so decoding is a mask compare.
package gb_mbc_pkg;

    localparam logic [15:0] ROM0_BASE  = 16'h0000;
    localparam logic [15:0] ROM0_LIMIT = 16'h3FFF;
    localparam logic [15:0] ROMX_BASE  = 16'h4000;
    localparam logic [15:0] ROMX_LIMIT = 16'h7FFF;
    localparam logic [15:0] RAMG_BASE  = 16'h0000;
    localparam logic [15:0] RAMG_LIMIT = 16'h1FFF;
    localparam logic [15:0] BANK1_BASE  = 16'h2000;
    localparam logic [15:0] BANK1_LIMIT = 16'h3FFF;
    localparam logic [15:0] BANK2_BASE  = 16'h4000;
    localparam logic [15:0] BANK2_LIMIT = 16'h5FFF;
    localparam logic [15:0] MODE_BASE  = 16'h6000;
    localparam logic [15:0] MODE_LIMIT = 16'h7FFF;
    localparam logic [15:0] XRAM_BASE  = 16'hA000;
    localparam logic [15:0] XRAM_LIMIT = 16'hBFFF;

    localparam logic [3:0] RAM_EN_KEY = 4'hA;
    localparam logic [7:0] OPEN_BUS   = 8'hFF;

    // ROM regions overlap the register-write regions, so one flag per region.
    typedef struct packed {
        logic rom0;
        logic romx;
        logic ramg;
        logic bank1;
        logic bank2;
        logic mode;
        logic xram;
    } region_t;

    function automatic logic in_region(input logic [15:0] addr,
                                       input logic [15:0] base,
                                       input logic [15:0] limit);
        return (addr & ~(limit - base)) == base;
    endfunction

endpackage

// File: rtl/mbc_decode.sv
// CPU address to region flags; shared by all bank-controller variants.
module mbc_decode
    import gb_mbc_pkg::*;
(
    input  logic [15:0] i_addr,
    output region_t     o_region
);

    always_comb begin
        o_region       = '0;
        o_region.rom0  = in_region(i_addr, ROM0_BASE,  ROM0_LIMIT);
        o_region.romx  = in_region(i_addr, ROMX_BASE,  ROMX_LIMIT);
        o_region.ramg  = in_region(i_addr, RAMG_BASE,  RAMG_LIMIT);
        o_region.bank1 = in_region(i_addr, BANK1_BASE, BANK1_LIMIT);
        o_region.bank2 = in_region(i_addr, BANK2_BASE, BANK2_LIMIT);
        o_region.mode  = in_region(i_addr, MODE_BASE,  MODE_LIMIT);
        o_region.xram  = in_region(i_addr, XRAM_BASE,  XRAM_LIMIT);
    end

endmodule

// File: rtl/mbc_banked.sv
// MBC1-style bank controller: control registers, ROM/RAM address translation
// and the CPU read mux. All outputs are combinational from the current registers.
module mbc_banked
    import gb_mbc_pkg::*;
#(
    parameter int ROM_BANK_BITS = 7,
    parameter int RAM_BANK_BITS = 2,
    parameter int RAM_PRESENT   = 1
) (
    input  logic                          clockgb,
    input  logic                          resetn,
    input  logic [15:0]                   address,
    input  logic [7:0]                    indata,
    output logic [7:0]                    outdata,
    input  logic                          load,
    input  logic                          store,
    output logic [14+ROM_BANK_BITS-1:0]   rom_addr,
    output logic                          rom_sel,
    input  logic [7:0]                    rom_data,
    output logic [13+RAM_BANK_BITS-1:0]   ram_addr,
    output logic                          ram_sel,
    output logic                          ram_store,
    input  logic [7:0]                    ram_data,
    output logic                          ram_enabled
);

    localparam logic HAS_RAM = (RAM_PRESENT != 0);

    region_t w_region;

    logic       r_ram_en;
    logic [4:0] r_bank_lo;
    logic [1:0] r_bank_hi;
    logic       r_mode;

    mbc_decode u_decode (
        .i_addr   (address),
        .o_region (w_region)
    );

    always_ff @(posedge clockgb) begin
        if (!resetn) begin
            r_ram_en  <= 1'b0;
            r_bank_lo <= 5'd1;
            r_bank_hi <= 2'd0;
            r_mode    <= 1'b0;
        end else if (store) begin
            if (w_region.ramg)
                r_ram_en <= (indata[3:0] == RAM_EN_KEY);
            // Bank 0 is never selectable in the upper window; 0x20/0x40/0x60 alias to 1.
            if (w_region.bank1)
                r_bank_lo <= (indata[4:0] == 5'd0) ? 5'd1 : indata[4:0];
            if (w_region.bank2)
                r_bank_hi <= indata[1:0];
            if (w_region.mode)
                r_mode <= indata[0];
        end
    end

    logic [6:0]               w_bank_full;
    logic [6:0]               w_bank_hi_only;
    logic [ROM_BANK_BITS-1:0] w_rom_bank;

    assign w_bank_full    = {r_bank_hi, r_bank_lo};
    assign w_bank_hi_only = {r_bank_hi, 5'b0};

    always_comb begin
        w_rom_bank = '0;
        if (w_region.romx)
            w_rom_bank = w_bank_full[ROM_BANK_BITS-1:0];
        else if (r_mode)
            w_rom_bank = w_bank_hi_only[ROM_BANK_BITS-1:0];
    end

    assign rom_addr = {w_rom_bank, address[13:0]};
    assign rom_sel  = load & (w_region.rom0 | w_region.romx);

    generate
        if (RAM_BANK_BITS > 0) begin : g_ram_rank
            logic [RAM_BANK_BITS-1:0] w_rank;
            assign w_rank   = r_mode ? r_bank_hi[RAM_BANK_BITS-1:0] : '0;
            assign ram_addr = {w_rank, address[12:0]};
        end else begin : g_ram_flat
            assign ram_addr = address[12:0];
        end
    endgenerate

    logic w_ram_ok;

    assign w_ram_ok    = w_region.xram & r_ram_en & HAS_RAM;
    assign ram_sel     = w_ram_ok & (load | store);
    assign ram_store   = w_ram_ok & store;
    assign ram_enabled = r_ram_en;

    always_comb begin
        outdata = OPEN_BUS;
        if (load) begin
            if (w_region.rom0 | w_region.romx)
                outdata = rom_data;
            else if (w_ram_ok)
                outdata = ram_data;
        end
    end

    // Bits that go unread for some parameter choices.
    logic w_unused;
    assign w_unused = ^{indata[7:5], w_bank_full, w_bank_hi_only, ram_data};

endmodule

// File: tb/tb_mbc_banked.sv
// Bench for mbc_banked: a full-featured build and a small RAM-less build share stimulus.
module tb_mbc_banked;

    logic        clockgb;
    logic        resetn;
    logic [15:0] address;
    logic [7:0]  indata;
    logic        load;
    logic        store;
    logic [7:0]  rom_data;
    logic [7:0]  ram_data;

    logic [7:0]  a_outdata;
    logic [20:0] a_rom_addr;
    logic        a_rom_sel;
    logic [14:0] a_ram_addr;
    logic        a_ram_sel;
    logic        a_ram_store;
    logic        a_ram_enabled;

    logic [7:0]  b_outdata;
    logic [18:0] b_rom_addr;
    logic        b_rom_sel;
    logic [12:0] b_ram_addr;
    logic        b_ram_sel;
    logic        b_ram_store;
    logic        b_ram_enabled;

    mbc_banked #(.ROM_BANK_BITS(7), .RAM_BANK_BITS(2), .RAM_PRESENT(1)) u_dut_a (
        .clockgb(clockgb), .resetn(resetn), .address(address), .indata(indata),
        .outdata(a_outdata), .load(load), .store(store),
        .rom_addr(a_rom_addr), .rom_sel(a_rom_sel), .rom_data(rom_data),
        .ram_addr(a_ram_addr), .ram_sel(a_ram_sel), .ram_store(a_ram_store),
        .ram_data(ram_data), .ram_enabled(a_ram_enabled)
    );

    mbc_banked #(.ROM_BANK_BITS(5), .RAM_BANK_BITS(0), .RAM_PRESENT(0)) u_dut_b (
        .clockgb(clockgb), .resetn(resetn), .address(address), .indata(indata),
        .outdata(b_outdata), .load(load), .store(store),
        .rom_addr(b_rom_addr), .rom_sel(b_rom_sel), .rom_data(rom_data),
        .ram_addr(b_ram_addr), .ram_sel(b_ram_sel), .ram_store(b_ram_store),
        .ram_data(ram_data), .ram_enabled(b_ram_enabled)
    );

    initial clockgb = 1'b0;
    always #5 clockgb = ~clockgb;

    typedef struct {
        logic        rstn;
        logic [15:0] addr;
        logic [7:0]  din;
        logic        ld;
        logic        st;
        logic [20:0] ra;
        logic [14:0] xa;
        logic        rs;
        logic        xs;
        logic        xw;
        logic [7:0]  od;
        logic        en;
        logic [18:0] ra_b;
        logic [7:0]  od_b;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   pass_cnt = 0;
    int   tot_cnt  = 0;

    function automatic vec_t mk(input int rstn, input int a, input int d, input int ld,
                                input int st, input int ra, input int xa, input int rs,
                                input int xs, input int xw, input int od, input int en,
                                input int rb, input int ob);
        vec_t v;
        v.rstn = rstn[0];   v.addr = a[15:0];   v.din = d[7:0];
        v.ld   = ld[0];     v.st   = st[0];
        v.ra   = ra[20:0];  v.xa   = xa[14:0];
        v.rs   = rs[0];     v.xs   = xs[0];     v.xw  = xw[0];
        v.od   = od[7:0];   v.en   = en[0];
        v.ra_b = rb[18:0];  v.od_b = ob[7:0];
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        tot_cnt++;
        if (act !== exp)
            $display("FAIL %s step %0d: got %h, want %h", nm, idx, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic check_head(input int idx);
        vec_t e;
        if (sb.size() == 0) begin
            tot_cnt++;
            $display("FAIL scoreboard step %0d: got empty queue, want entry", idx);
        end else begin
            e = sb.pop_front();
            chk("a_rom_addr",    idx, 32'(a_rom_addr),    32'(e.ra));
            chk("a_ram_addr",    idx, 32'(a_ram_addr),    32'(e.xa));
            chk("a_rom_sel",     idx, 32'(a_rom_sel),     32'(e.rs));
            chk("a_ram_sel",     idx, 32'(a_ram_sel),     32'(e.xs));
            chk("a_ram_store",   idx, 32'(a_ram_store),   32'(e.xw));
            chk("a_outdata",     idx, 32'(a_outdata),     32'(e.od));
            chk("a_ram_enabled", idx, 32'(a_ram_enabled), 32'(e.en));
            chk("b_rom_addr",    idx, 32'(b_rom_addr),    32'(e.ra_b));
            chk("b_ram_addr",    idx, 32'(b_ram_addr),    32'(e.addr[12:0]));
            chk("b_rom_sel",     idx, 32'(b_rom_sel),     32'(e.rs));
            chk("b_ram_sel",     idx, 32'(b_ram_sel),     32'd0);
            chk("b_ram_store",   idx, 32'(b_ram_store),   32'd0);
            chk("b_outdata",     idx, 32'(b_outdata),     32'(e.od_b));
            chk("b_ram_enabled", idx, 32'(b_ram_enabled), 32'(e.en));
        end
    endtask

    // Drive just after a rising edge, check at the falling edge; the next
    // rising edge commits any register write carried by this step.
    task automatic apply(input vec_t v, input int idx);
        @(posedge clockgb);
        #1;
        resetn  = v.rstn;
        address = v.addr;
        indata  = v.din;
        load    = v.ld;
        store   = v.st;
        sb.push_back(v);
        @(negedge clockgb);
        check_head(idx);
    endtask

    initial begin
        resetn   = 1'b0;
        address  = 16'h0000;
        indata   = 8'h00;
        load     = 1'b0;
        store    = 1'b0;
        rom_data = 8'h5A;
        ram_data = 8'hC3;
        repeat (2) @(posedge clockgb);

        //              rstn addr     din  ld st  rom_addr   ram_addr rs xs xw od    en rom_b     od_b
        vecs.push_back(mk(1, 'h4000, 'h00, 1, 0, 'h004000, 'h0000, 1, 0, 0, 'h5A, 0, 'h04000, 'h5A));
        vecs.push_back(mk(1, 'hA000, 'h00, 1, 0, 'h002000, 'h0000, 0, 0, 0, 'hFF, 0, 'h02000, 'hFF));
        vecs.push_back(mk(1, 'h0000, 'h00, 0, 0, 'h000000, 'h0000, 0, 0, 0, 'hFF, 0, 'h00000, 'hFF));
        vecs.push_back(mk(1, 'h2100, 'h00, 0, 1, 'h002100, 'h0100, 0, 0, 0, 'hFF, 0, 'h02100, 'hFF));
        vecs.push_back(mk(1, 'h4123, 'h00, 1, 0, 'h004123, 'h0123, 1, 0, 0, 'h5A, 0, 'h04123, 'h5A));
        vecs.push_back(mk(1, 'h2000, 'h20, 0, 1, 'h002000, 'h0000, 0, 0, 0, 'hFF, 0, 'h02000, 'hFF));
        vecs.push_back(mk(1, 'h4123, 'h00, 1, 0, 'h004123, 'h0123, 1, 0, 0, 'h5A, 0, 'h04123, 'h5A));
        vecs.push_back(mk(1, 'h2000, 'h1F, 0, 1, 'h002000, 'h0000, 0, 0, 0, 'hFF, 0, 'h02000, 'hFF));
        vecs.push_back(mk(1, 'h4000, 'h03, 0, 1, 'h07C000, 'h0000, 0, 0, 0, 'hFF, 0, 'h7C000, 'hFF));
        vecs.push_back(mk(1, 'h7FFF, 'h00, 1, 0, 'h1FFFFF, 'h1FFF, 1, 0, 0, 'h5A, 0, 'h7FFFF, 'h5A));
        vecs.push_back(mk(1, 'h6000, 'h01, 0, 1, 'h1FE000, 'h0000, 0, 0, 0, 'hFF, 0, 'h7E000, 'hFF));
        vecs.push_back(mk(1, 'h4000, 'h02, 0, 1, 'h1FC000, 'h6000, 0, 0, 0, 'hFF, 0, 'h7C000, 'hFF));
        vecs.push_back(mk(1, 'h0010, 'h00, 1, 0, 'h100010, 'h4010, 1, 0, 0, 'h5A, 0, 'h00010, 'h5A));
        vecs.push_back(mk(1, 'hA005, 'h00, 1, 0, 'h102005, 'h4005, 0, 0, 0, 'hFF, 0, 'h02005, 'hFF));
        vecs.push_back(mk(1, 'h6000, 'h00, 0, 1, 'h17E000, 'h4000, 0, 0, 0, 'hFF, 0, 'h7E000, 'hFF));
        vecs.push_back(mk(1, 'h0010, 'h00, 1, 0, 'h000010, 'h0010, 1, 0, 0, 'h5A, 0, 'h00010, 'h5A));
        vecs.push_back(mk(1, 'hA005, 'h00, 1, 0, 'h002005, 'h0005, 0, 0, 0, 'hFF, 0, 'h02005, 'hFF));
        vecs.push_back(mk(1, 'h0000, 'h0A, 0, 1, 'h000000, 'h0000, 0, 0, 0, 'hFF, 0, 'h00000, 'hFF));
        vecs.push_back(mk(1, 'hB000, 'h77, 0, 1, 'h003000, 'h1000, 0, 1, 1, 'hFF, 1, 'h03000, 'hFF));
        vecs.push_back(mk(1, 'hB000, 'h00, 1, 0, 'h003000, 'h1000, 0, 1, 0, 'hC3, 1, 'h03000, 'hFF));
        vecs.push_back(mk(1, 'h0000, 'h0B, 1, 1, 'h000000, 'h0000, 1, 0, 0, 'h5A, 1, 'h00000, 'h5A));
        vecs.push_back(mk(1, 'hB000, 'h77, 0, 1, 'h003000, 'h1000, 0, 0, 0, 'hFF, 0, 'h03000, 'hFF));
        vecs.push_back(mk(1, 'hB000, 'h00, 1, 0, 'h003000, 'h1000, 0, 0, 0, 'hFF, 0, 'h03000, 'hFF));
        vecs.push_back(mk(1, 'h1FFF, 'h0A, 0, 1, 'h001FFF, 'h1FFF, 0, 0, 0, 'hFF, 0, 'h01FFF, 'hFF));
        vecs.push_back(mk(1, 'hA000, 'h00, 1, 0, 'h002000, 'h0000, 0, 1, 0, 'hC3, 1, 'h02000, 'hFF));
        vecs.push_back(mk(1, 'h0000, 'h1A, 0, 1, 'h000000, 'h0000, 0, 0, 0, 'hFF, 1, 'h00000, 'hFF));
        vecs.push_back(mk(1, 'hA000, 'h00, 1, 0, 'h002000, 'h0000, 0, 1, 0, 'hC3, 1, 'h02000, 'hFF));
        vecs.push_back(mk(1, 'h2000, 'h05, 0, 1, 'h002000, 'h0000, 0, 0, 0, 'hFF, 1, 'h02000, 'hFF));
        vecs.push_back(mk(1, 'h6000, 'h01, 0, 1, 'h116000, 'h0000, 0, 0, 0, 'hFF, 1, 'h16000, 'hFF));
        vecs.push_back(mk(0, 'h4000, 'h00, 1, 0, 'h114000, 'h4000, 1, 0, 0, 'h5A, 1, 'h14000, 'h5A));
        vecs.push_back(mk(1, 'h4000, 'h00, 1, 0, 'h004000, 'h0000, 1, 0, 0, 'h5A, 0, 'h04000, 'h5A));
        vecs.push_back(mk(1, 'hA000, 'h00, 1, 0, 'h002000, 'h0000, 0, 0, 0, 'hFF, 0, 'h02000, 'hFF));
        vecs.push_back(mk(1, 'hC000, 'h00, 1, 0, 'h000000, 'h0000, 0, 0, 0, 'hFF, 0, 'h00000, 'hFF));

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], i);

        // Enable key held for three cycles: no edge detection, stays enabled.
        apply(mk(1, 'h0000, 'h0A, 0, 1, 'h000000, 'h0000, 0, 0, 0, 'hFF, 0, 'h00000, 'hFF), 100);
        apply(mk(1, 'h0000, 'h0A, 0, 1, 'h000000, 'h0000, 0, 0, 0, 'hFF, 1, 'h00000, 'hFF), 101);
        apply(mk(1, 'h0000, 'h0A, 0, 1, 'h000000, 'h0000, 0, 0, 0, 'hFF, 1, 'h00000, 'hFF), 102);

        // Reset lands in the middle of a RAM write; strobe drops the cycle after.
        apply(mk(0, 'hA000, 'h55, 0, 1, 'h002000, 'h0000, 0, 1, 1, 'hFF, 1, 'h02000, 'hFF), 103);
        apply(mk(1, 'hA000, 'h55, 0, 1, 'h002000, 'h0000, 0, 0, 0, 'hFF, 0, 'h02000, 'hFF), 104);

        tot_cnt++;
        if (sb.size() != 0)
            $display("FAIL scoreboard drain: got %0d left, want 0", sb.size());
        else
            pass_cnt++;

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
